// File: rtl/sub_pkg.sv
// Shared constants and FSM state type for the nibble-serial subtractor.
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/nibble_subtractor.sv
// Combinational 4-bit ripple-borrow subtractor: {bo, D} = A - B - bi,
// built from four full-subtractor bit slices.
module nibble_subtractor (
    output logic       bo,
    output logic [3:0] D,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       bi
);

    logic [4:0] w_brw;

    assign w_brw[0] = bi;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        logic w_x;
        assign w_x          = A[i] ^ B[i];
        assign D[i]         = w_x ^ w_brw[i];
        // Borrow out when a < b, or a == b with a borrow coming in.
        assign w_brw[i + 1] = (~A[i] & B[i]) | (~w_x & w_brw[i]);
    end

    assign bo = w_brw[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor, one nibble per clock, LS nibble first.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int N = 24
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] DIFF,
    output logic         bo
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NIB = N / NIBBLE_W;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] LAST = KW'(NIB - 1);

    sub_state_t    r_state;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_diff;
    logic          r_borrow;
    logic          r_bo;
`ifdef SUB_OVF_EN
    logic          r_ovf;
`endif

    logic [31:0]         w_lo;
    logic [NIBBLE_W-1:0] w_an;
    logic [NIBBLE_W-1:0] w_bn;
    logic [NIBBLE_W-1:0] w_d;
    logic                w_bo;

    assign w_lo = 32'(r_k) * NIBBLE_W;
    assign w_an = r_a[w_lo +: NIBBLE_W];
    assign w_bn = r_b[w_lo +: NIBBLE_W];

    nibble_subtractor u_nib (
        .bo (w_bo),
        .D  (w_d),
        .A  (w_an),
        .B  (w_bn),
        .bi (r_borrow)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bo     <= 1'b0;
`ifdef SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= bi;
                        r_diff   <= '0;
                        r_k      <= '0;
                        r_bo     <= 1'b0;
`ifdef SUB_OVF_EN
                        r_ovf    <= 1'b0;
`endif
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_diff[w_lo +: NIBBLE_W] <= w_d;
                    r_borrow                 <= w_bo;
                    if (r_k == LAST) begin
                        r_bo    <= w_bo;
`ifdef SUB_OVF_EN
                        // w_d[3] is the sign bit of the finished difference here.
                        r_ovf   <= (r_a[N-1] != r_b[N-1]) & (w_d[NIBBLE_W-1] != r_a[N-1]);
`endif
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = (r_state == DONE);
    assign DIFF      = r_diff;
    assign bo        = r_bo;
`ifdef SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (N=24): directed cases
// plus random operands against an arithmetic reference model.
module tb_nibble_serial_subtractor;

    localparam int N = 24;
    localparam longint MASK = (64'd1 << N) - 1;

    logic         ck = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] DIFF;
    logic         bo;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    nibble_serial_subtractor #(.N(N)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DIFF      (DIFF),
        .bo        (bo)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Reference: plain unsigned arithmetic on the full operands.
    task automatic check_result(input string tag, input longint a, input longint b, input longint c);
        longint d;
        logic   eb;
        d  = (a - b - c) & MASK;
        eb = (a < b + c);
        chk({tag, "_diff"}, longint'(DIFF), d);
        chk({tag, "_bo"}, longint'(bo), longint'(eb));
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, longint'(ovf),
            longint'((a[N-1] != b[N-1]) && (d[N-1] != a[N-1])));
`endif
    endtask

    // Runs one operation; hold = number of DONE cycles with out_ready low.
    task automatic do_op(input string tag, input longint a, input longint b,
                         input logic c, input int hold);
        int           lat;
        logic [N-1:0] held;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
        A = a[N-1:0]; B = b[N-1:0]; bi = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = '0; B = '0; bi = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, N / 4);
        check_result(tag, a, b, longint'(c));
        held = DIFF;
        for (int i = 0; i < hold; i++) begin
            A = N'($urandom); B = N'($urandom); in_valid = 1'b1;
            tick();
            chk({tag, "_bp_valid"}, longint'(out_valid), 1);
            chk({tag, "_bp_ready"}, longint'(in_ready), 0);
            chk({tag, "_bp_diff"}, longint'(DIFF), longint'(held));
            check_result({tag, "_bp"}, a, b, longint'(c));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk({tag, "_ov_drop"}, longint'(out_valid), 0);
        chk({tag, "_idle"}, longint'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        longint ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bi = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_diff", longint'(DIFF), 0);
        chk("rst_bo", longint'(bo), 0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", longint'(ovf), 0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", longint'(in_ready), 1);

        do_op("nib_borrow", 64'h000010, 64'h000001, 1'b0, 0);
        chk("nib_borrow_val", longint'(DIFF), 64'h00000F);
        do_op("underflow", 64'h000000, 64'h000001, 1'b0, 0);
        do_op("bi_only", 64'h123456, 64'h123456, 1'b1, 0);
        do_op("backpress", 64'hABCDEF, 64'h12F0F1, 1'b1, 5);
        do_op("max_min", MASK, 64'h0, 1'b1, 0);
        do_op("sovf", 64'h7FFFFF, 64'hFFFFFF, 1'b0, 0);
        do_op("sovf2", 64'h800000, 64'h000001, 1'b0, 1);

        // Abort mid-RUN: rst sampled on the third RUN edge.
        A = 24'h00F00F; B = 24'h0F00F0; bi = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_diff", longint'(DIFF), 0);
        chk("abort_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("abort_idle", longint'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_result", longint'(out_valid), 0);
        end
        do_op("after_abort", 64'h000005, 64'h000003, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = longint'($urandom) & MASK;
            rb = longint'($urandom) & MASK;
            if (i % 7 == 0) rb = ra;
            do_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
